// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// ------------
// VGA raster timing generator, 640x480@60 by default, running from the
// system clock with a programmable clock divider to reach the pixel rate.
// It feeds the frame renderer's pixel-coordinate interface and drives the
// connector syncs. The syncs are delayed to match the renderer's colour
// pipeline, so sync and colour arrive at the connector together.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   o_pix_valid    high while the current pixel is in the visible region
//   o_col          visible column (0 outside the visible region)
//   o_row          visible row    (0 outside the visible region)
//   o_hsync        horizontal sync at SYNC_ACTIVE level, delayed SYNC_DELAY clocks
//   o_vsync        vertical sync at SYNC_ACTIVE level, delayed SYNC_DELAY clocks
//   o_frame_start  one-clock pulse on the first clock of pixel (0,0)
module vga_sync_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   CLK_DIV     = 2,     // 1..4
    parameter int   SYNC_DELAY  = 2,     // 0..7
    parameter logic SYNC_ACTIVE = 1'b0   // 0 = active-low syncs
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_pix_valid,
    output logic [9:0] o_col,
    output logic [9:0] o_row,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [1:0] div_cnt_reg;
    logic [9:0] h_cnt_reg;
    logic [9:0] v_cnt_reg;
    logic       pix_tick;

    assign pix_tick = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= 2'd0;
            h_cnt_reg   <= 10'd0;
            v_cnt_reg   <= 10'd0;
        end else begin
            if (pix_tick) begin
                div_cnt_reg <= 2'd0;
                if (h_cnt_reg == H_LAST) begin
                    h_cnt_reg <= 10'd0;
                    if (v_cnt_reg == V_LAST) begin
                        v_cnt_reg <= 10'd0;
                    end else begin
                        v_cnt_reg <= v_cnt_reg + 10'd1;
                    end
                end else begin
                    h_cnt_reg <= h_cnt_reg + 10'd1;
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel interface. Outputs are registered straight from the counters,
    // so they change only on the clock after a tick and stay constant for
    // all CLK_DIV clocks of a pixel.
    // ------------------------------------------------------------------
    logic visible;
    logic first_clk_of_frame;

    assign visible            = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    assign first_clk_of_frame = (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0) &&
                                (div_cnt_reg == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_pix_valid   <= 1'b0;
            o_col         <= 10'd0;
            o_row         <= 10'd0;
            o_frame_start <= 1'b0;
        end else begin
            o_pix_valid   <= visible;
            o_col         <= visible ? h_cnt_reg : 10'd0;
            o_row         <= visible ? v_cnt_reg : 10'd0;
            o_frame_start <= first_clk_of_frame;
        end
    end

    // ------------------------------------------------------------------
    // Sync generation and delay line. Stage 0 is aligned with o_col/o_row;
    // each further stage adds one clock, so the output stage SYNC_DELAY
    // carries exactly SYNC_DELAY clocks of delay. The line shifts every
    // clock (not on pixel ticks) because the renderer latency is in clocks.
    // ------------------------------------------------------------------
    logic hs_raw;
    logic vs_raw;
    logic hs_lvl;
    logic vs_lvl;

    assign hs_raw = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
    assign vs_raw = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
    assign hs_lvl = hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs_lvl = vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    logic [SYNC_DELAY:0] hs_pipe_reg;
    logic [SYNC_DELAY:0] vs_pipe_reg;
    logic [SYNC_DELAY:0] hs_pipe_next;
    logic [SYNC_DELAY:0] vs_pipe_next;

    generate
        for (genvar gi = 0; gi <= SYNC_DELAY; gi++) begin : g_sync_pipe
            if (gi == 0) begin : g_head
                assign hs_pipe_next[gi] = hs_lvl;
                assign vs_pipe_next[gi] = vs_lvl;
            end else begin : g_tail
                assign hs_pipe_next[gi] = hs_pipe_reg[gi-1];
                assign vs_pipe_next[gi] = vs_pipe_reg[gi-1];
            end
        end
    endgenerate

    // Reset flushes the whole line to the inactive level so an aborted
    // sync pulse cannot leak out after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pipe_reg <= {(SYNC_DELAY+1){~SYNC_ACTIVE}};
            vs_pipe_reg <= {(SYNC_DELAY+1){~SYNC_ACTIVE}};
        end else begin
            hs_pipe_reg <= hs_pipe_next;
            vs_pipe_reg <= vs_pipe_next;
        end
    end

    assign o_hsync = hs_pipe_reg[SYNC_DELAY];
    assign o_vsync = vs_pipe_reg[SYNC_DELAY];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// ---------------
// Directed bench for vga_sync_gen. Three instances share one clock:
//   dut_a : default timing (reset and horizontal timing)
//   dut_b : default horizontal, short vertical (4/1/2/1 lines), CLK_DIV=2,
//           SYNC_DELAY=2 (vertical timing, renderer alignment, mid-frame reset)
//   dut_c : same short vertical, CLK_DIV=1, SYNC_DELAY=0
// The short vertical raster keeps whole frames affordable in simulation.
// Edge numbering: edge 1 is the first rising edge with rst low; outputs are
// sampled 1 time unit after the edge.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic       pv_a, pv_b, pv_c;
    logic [9:0] col_a, col_b, col_c;
    logic [9:0] row_a, row_b, row_c;
    logic       hs_a, hs_b, hs_c;
    logic       vs_a, vs_b, vs_c;
    logic       fs_a, fs_b, fs_c;

    vga_sync_gen dut_a (
        .clk(clk), .rst(rst_a), .o_pix_valid(pv_a), .o_col(col_a), .o_row(row_a),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_frame_start(fs_a)
    );

    vga_sync_gen #(
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2), .SYNC_DELAY(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .o_pix_valid(pv_b), .o_col(col_b), .o_row(row_b),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_frame_start(fs_b)
    );

    vga_sync_gen #(
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(1), .SYNC_DELAY(0)
    ) dut_c (
        .clk(clk), .rst(rst_c), .o_pix_valid(pv_c), .o_col(col_c), .o_row(row_c),
        .o_hsync(hs_c), .o_vsync(vs_c), .o_frame_start(fs_c)
    );

    int checks   = 0;
    int failures = 0;
    int cur      = 0;   // index of the last edge passed

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, cur, obs, exp);
        end else begin
            $display("ok   %s edge=%0d value=%0d", tag, cur, obs);
        end
    endtask

    // Advance to edge n (relative to the last reset release) and settle.
    task automatic goto_edge(input int n);
        while (cur < n) begin
            @(posedge clk);
            cur++;
        end
        #1;
    endtask

    logic d1, d2;
    int   colour_on, colour_in_hsync, hs_low;

    initial begin
        // ---------------- dut_a: reset + horizontal timing ----------------
        repeat (5) @(posedge clk);
        #1;
        check("a_rst_valid", 32'(pv_a), 0);
        check("a_rst_col",   32'(col_a), 0);
        check("a_rst_row",   32'(row_a), 0);
        check("a_rst_fs",    32'(fs_a), 0);
        check("a_rst_hs",    32'(hs_a), 1);
        check("a_rst_vs",    32'(vs_a), 1);
        rst_a = 1'b0;
        cur   = 0;
        goto_edge(1);
        check("a_e1_valid", 32'(pv_a), 1);
        check("a_e1_col",   32'(col_a), 0);
        check("a_e1_row",   32'(row_a), 0);
        check("a_e1_fs",    32'(fs_a), 1);
        check("a_e1_hs",    32'(hs_a), 1);
        goto_edge(2);
        check("a_e2_fs",  32'(fs_a), 0);
        check("a_e2_col", 32'(col_a), 0);
        goto_edge(3);
        check("a_e3_col", 32'(col_a), 1);
        goto_edge(1280);
        check("a_last_valid", 32'(pv_a), 1);
        check("a_last_col",   32'(col_a), 639);
        goto_edge(1281);
        check("a_blank_valid", 32'(pv_a), 0);
        check("a_blank_col",   32'(col_a), 0);
        goto_edge(1314);
        check("a_hs_before", 32'(hs_a), 1);
        goto_edge(1315);
        check("a_hs_fall", 32'(hs_a), 0);
        goto_edge(1506);
        check("a_hs_held", 32'(hs_a), 0);
        goto_edge(1507);
        check("a_hs_rise", 32'(hs_a), 1);
        goto_edge(1600);
        check("a_eol_valid", 32'(pv_a), 0);
        goto_edge(1601);
        check("a_l1_valid", 32'(pv_a), 1);
        check("a_l1_row",   32'(row_a), 1);
        check("a_l1_col",   32'(col_a), 0);
        check("a_l1_fs",    32'(fs_a), 0);
        check("a_l1_vs",    32'(vs_a), 1);
        rst_a = 1'b1;

        // ---------------- dut_b: vertical, renderer, mid-frame reset -------
        rst_b = 1'b0;
        cur   = 0;
        goto_edge(1);
        check("b_e1_fs", 32'(fs_b), 1);
        // Renderer model: colour is pix_valid delayed two clocks.
        d1 = 1'b0; d2 = 1'b0;
        colour_on = 0; colour_in_hsync = 0; hs_low = 0;
        for (int k = 1599; k <= 3200; k++) begin
            goto_edge(k);
            if (k >= 1601) begin
                if (d2) colour_on++;
                if (d2 && !hs_b) colour_in_hsync++;
                if (!hs_b) hs_low++;
            end
            d2 = d1;
            d1 = pv_b;
        end
        check("b_colour_clocks", 32'(colour_on), 1280);
        check("b_colour_in_hs",  32'(colour_in_hsync), 0);
        check("b_hs_low_clocks", 32'(hs_low), 192);
        goto_edge(6079);
        check("b_l3_valid", 32'(pv_b), 1);
        check("b_l3_row",   32'(row_b), 3);
        check("b_l3_col",   32'(col_b), 639);
        goto_edge(6401);
        check("b_l4_valid", 32'(pv_b), 0);
        check("b_l4_row",   32'(row_b), 0);
        goto_edge(8002);
        check("b_vs_before", 32'(vs_b), 1);
        goto_edge(8003);
        check("b_vs_fall", 32'(vs_b), 0);
        goto_edge(11202);
        check("b_vs_held", 32'(vs_b), 0);
        goto_edge(11203);
        check("b_vs_rise", 32'(vs_b), 1);
        goto_edge(12800);
        check("b_pre_fs", 32'(fs_b), 0);
        goto_edge(12801);
        check("b_f2_fs",    32'(fs_b), 1);
        check("b_f2_valid", 32'(pv_b), 1);
        check("b_f2_row",   32'(row_b), 0);
        check("b_f2_col",   32'(col_b), 0);
        goto_edge(12802);
        check("b_f2_fs_end", 32'(fs_b), 0);
        // Line 2, column 700 of frame 2: hsync pulse in flight.
        goto_edge(17401);
        check("b_mid_hs", 32'(hs_b), 0);
        rst_b = 1'b1;
        @(posedge clk);
        cur++;
        #1;
        check("b_mrst_valid", 32'(pv_b), 0);
        check("b_mrst_col",   32'(col_b), 0);
        check("b_mrst_row",   32'(row_b), 0);
        check("b_mrst_fs",    32'(fs_b), 0);
        check("b_mrst_hs",    32'(hs_b), 1);
        rst_b = 1'b0;
        cur   = 0;
        goto_edge(1);
        check("b_re1_valid", 32'(pv_b), 1);
        check("b_re1_fs",    32'(fs_b), 1);
        check("b_re1_col",   32'(col_b), 0);
        check("b_re1_hs",    32'(hs_b), 1);
        goto_edge(2);
        check("b_re2_hs", 32'(hs_b), 1);
        check("b_re2_fs", 32'(fs_b), 0);
        goto_edge(3);
        check("b_re3_hs",  32'(hs_b), 1);
        check("b_re3_col", 32'(col_b), 1);
        rst_b = 1'b1;

        // ---------------- dut_c: CLK_DIV=1, SYNC_DELAY=0 ------------------
        rst_c = 1'b0;
        cur   = 0;
        goto_edge(1);
        check("c_e1_fs",  32'(fs_c), 1);
        check("c_e1_col", 32'(col_c), 0);
        goto_edge(2);
        check("c_e2_col", 32'(col_c), 1);
        check("c_e2_fs",  32'(fs_c), 0);
        goto_edge(3);
        check("c_e3_col", 32'(col_c), 2);
        goto_edge(640);
        check("c_last_col", 32'(col_c), 639);
        goto_edge(641);
        check("c_blank_valid", 32'(pv_c), 0);
        goto_edge(656);
        check("c_hs_before", 32'(hs_c), 1);
        goto_edge(657);
        check("c_hs_fall", 32'(hs_c), 0);
        goto_edge(752);
        check("c_hs_held", 32'(hs_c), 0);
        goto_edge(753);
        check("c_hs_rise", 32'(hs_c), 1);
        goto_edge(801);
        check("c_l1_row", 32'(row_c), 1);
        goto_edge(4000);
        check("c_vs_before", 32'(vs_c), 1);
        goto_edge(4001);
        check("c_vs_fall", 32'(vs_c), 0);
        goto_edge(5600);
        check("c_vs_held", 32'(vs_c), 0);
        goto_edge(5601);
        check("c_vs_rise", 32'(vs_c), 1);
        goto_edge(6400);
        check("c_pre_fs", 32'(fs_c), 0);
        goto_edge(6401);
        check("c_f2_fs",  32'(fs_c), 1);
        check("c_f2_row", 32'(row_c), 0);
        rst_c = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
